// File: rtl/fetch_stage.sv
// RV32I instruction-fetch front end: fetch PC, ready/ack imem port, IF/D register, one-entry hold buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps (sticky misalign) instead of forcing alignment.
module fetch_stage #(
  parameter int                   D_WIDTH  = 32,
  parameter logic [D_WIDTH-1:0]   RESET_PC = '0,
  parameter logic [31:0]          NOP      = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               PCSrc,
  input  logic               JALR,
  input  logic [D_WIDTH-1:0] ImmExt,
  input  logic [D_WIDTH-1:0] reg1,
  output logic               imem_req,
  output logic [D_WIDTH-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr_D,
  output logic [D_WIDTH-1:0] PC_D,
  output logic               valid_D,
  output logic [D_WIDTH-1:0] inc_PC,
  output logic [D_WIDTH-1:0] PCTarget,
  output logic               misalign
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] pc_f_q, pc_f_d;
  logic [D_WIDTH-1:0] redir_q, redir_d;
  logic               kill_q, kill_d;
  logic [31:0]        ifd_instr_q, ifd_instr_d;
  logic [D_WIDTH-1:0] ifd_pc_q, ifd_pc_d;
  logic               ifd_valid_q, ifd_valid_d;
  logic [31:0]        hold_instr_q, hold_instr_d;
  logic [D_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic               misalign_q, misalign_d;

  logic [D_WIDTH-1:0] tgt_sum;
  logic [D_WIDTH-1:0] tgt_aligned;
  logic [D_WIDTH-1:0] pc_f_inc;
  logic               trap_hit;

  always_comb begin
    tgt_sum = (JALR ? reg1 : ifd_pc_q) + ImmExt;
    if (JALR) tgt_sum[0] = 1'b0;
  end

  assign tgt_aligned = {tgt_sum[D_WIDTH-1:2], 2'b00};
  assign pc_f_inc    = pc_f_q + D_WIDTH'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap_hit = |tgt_sum[1:0];
`else
  assign trap_hit = 1'b0;
`endif

  assign PCTarget  = tgt_sum;
  assign inc_PC    = ifd_pc_q + D_WIDTH'(4);
  assign imem_req  = !rst && (state_q == S_FETCH) && !misalign_q;
  assign imem_addr = pc_f_q;
  assign instr_D   = ifd_instr_q;
  assign PC_D      = ifd_pc_q;
  assign valid_D   = ifd_valid_q;
  assign misalign  = misalign_q;

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    redir_d      = redir_q;
    kill_d       = kill_q;
    ifd_instr_d  = ifd_instr_q;
    ifd_pc_d     = ifd_pc_q;
    ifd_valid_d  = ifd_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    misalign_d   = misalign_q;

    if (!misalign_q) begin
      if (PCSrc) begin
        ifd_valid_d = 1'b0;
        ifd_instr_d = NOP;
        state_d     = S_FETCH;
        if (trap_hit) begin
          misalign_d = 1'b1;
          kill_d     = 1'b0;
        end else if ((state_q == S_FETCH) && !imem_ack) begin
          // keep the outstanding address on the bus until its ack arrives
          kill_d  = 1'b1;
          redir_d = tgt_aligned;
        end else begin
          pc_f_d = tgt_aligned;
          kill_d = 1'b0;
        end
      end else if (kill_q) begin
        if (imem_ack) begin
          pc_f_d = redir_q;
          kill_d = 1'b0;
        end
        if (!stall) begin
          ifd_valid_d = 1'b0;
          ifd_instr_d = NOP;
        end
      end else if (state_q == S_HOLD) begin
        if (!stall) begin
          ifd_instr_d = hold_instr_q;
          ifd_pc_d    = hold_pc_q;
          ifd_valid_d = 1'b1;
          state_d     = S_FETCH;
        end
      end else if (imem_ack) begin
        pc_f_d = pc_f_inc;
        if (stall) begin
          hold_instr_d = imem_rdata;
          hold_pc_d    = pc_f_q;
          state_d      = S_HOLD;
        end else begin
          ifd_instr_d = imem_rdata;
          ifd_pc_d    = pc_f_q;
          ifd_valid_d = 1'b1;
        end
      end else if (!stall) begin
        // decode consumed the old word and nothing new arrived: bubble
        ifd_valid_d = 1'b0;
        ifd_instr_d = NOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_f_q       <= RESET_PC;
      redir_q      <= '0;
      kill_q       <= 1'b0;
      ifd_instr_q  <= NOP;
      ifd_pc_q     <= '0;
      ifd_valid_q  <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      redir_q      <= redir_d;
      kill_q       <= kill_d;
      ifd_instr_q  <= ifd_instr_d;
      ifd_pc_q     <= ifd_pc_d;
      ifd_valid_q  <= ifd_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns the address as data; accepted fetches go to a
// scoreboard queue and are popped when a fresh instruction appears in IF/D.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, PCSrc, JALR;
  logic [31:0] ImmExt, reg1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_D, PC_D, inc_PC, PCTarget;
  logic        valid_D, misalign;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        cur_stall;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .JALR(JALR),
    .ImmExt(ImmExt), .reg1(reg1), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_D(instr_D), .PC_D(PC_D),
    .valid_D(valid_D), .inc_PC(inc_PC), .PCTarget(PCTarget), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; check the request the DUT presents before the edge.
  task automatic drive(input logic st, input logic br, input logic jr, input logic [31:0] imm,
                       input logic [31:0] r1, input logic er, input logic ack,
                       input logic [31:0] ea, input logic push);
    stall      = st;
    PCSrc      = br;
    JALR       = jr;
    ImmExt     = imm;
    reg1       = r1;
    imem_ack   = ack;
    imem_rdata = ea;
    cur_stall  = st;
    if (push) exp_q.push_back(ea);
    #1;
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, ea);
  endtask

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (!cur_stall) begin
      if (valid_D) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_unexpected: observed PC_D %h expected no instruction", PC_D);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ifd_pc", PC_D, e);
          chk("ifd_instr", instr_D, e);
        end
      end else begin
        chk("bubble_nop", instr_D, NOP);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; PCSrc = 1'b0; JALR = 1'b0; ImmExt = '0; reg1 = '0;
    imem_ack = 1'b0; imem_rdata = '0; cur_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", valid_D, 1'b0);
    chk("rst_instr", instr_D, NOP);
    chk("rst_pc_d", PC_D, 32'h0);
    chk("rst_misalign", misalign, 1'b0);
    rst = 1'b0;

    // zero-wait stream from reset
    drive(0, 0, 0, 0, 0, 1, 1, 32'h0, 1); tick();
    chk("first_valid", valid_D, 1'b1);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h4, 1); tick();
    chk("inc_pc", inc_PC, 32'h8);

    // stall three cycles on the ack of 0x8
    drive(1, 0, 0, 0, 0, 1, 1, 32'h8, 1); tick();
    chk("stall_pc_d", PC_D, 32'h4);
    chk("stall_valid", valid_D, 1'b1);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 0); tick();
    chk("stall_pc_d2", PC_D, 32'h4);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'hC, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h10, 1); tick();

    // branch from 0x10 with offset -16; same-cycle ack is dropped
    drive(0, 1, 0, 32'hFFFF_FFF0, 0, 1, 1, 32'h14, 0);
    chk("br_target", PCTarget, 32'h0);
    tick();
    chk("br_bubble", valid_D, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h0, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h4, 1); tick();

    // JALR redirect while a 3-cycle request is outstanding
    drive(0, 1, 1, 32'h4, 32'h101, 1, 0, 32'h8, 0);
    chk("jalr_target", PCTarget, 32'h104);
    tick();
    chk("jalr_bubble", valid_D, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h8, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h8, 0); tick();
    chk("stale_dropped", valid_D, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h104, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0, 32'h104, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h104, 1); tick();

    // redirect to 0xFFFFFFFC, then wrap to 0
    drive(0, 1, 0, 32'hFFFF_FEF8, 0, 1, 1, 32'h108, 0);
    chk("wrap_target", PCTarget, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1); tick();
    chk("wrap_inc_pc", inc_PC, 32'h0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h0, 1); tick();

    // misaligned redirect to 0x102
    drive(0, 1, 0, 32'h102, 0, 1, 1, 32'h4, 0);
    chk("mis_target", PCTarget, 32'h102);
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", misalign, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 0); tick();
    chk("mis_sticky", misalign, 1'b1);
    chk("mis_valid", valid_D, 1'b0);
`else
    chk("mis_flag", misalign, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h100, 1); tick();
`endif

    chk("sb_drain", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end for the RV32I core: owns the fetch PC, drives a ready/ack instruction-memory port, and presents a registered instruction/PC pair (IF/D register) to decode and the datapath. Computes `inc_PC` and `PCTarget` for the datapath result mux from the decode-stage PC, `ImmExt` and `reg1`. Supports downstream stall, branch/jump redirect with flush, and variable-latency instruction memory through a one-entry hold buffer.

## Interface
- `D_WIDTH`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `NOP`, 32'h0000_0013, instruction presented when `valid_D`=0 (addi x0,x0,0)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  decode cannot accept; hold IF/D register
- `PCSrc`  in  1  redirect: instruction in D is a taken branch/jump
- `JALR`  in  1  target base is `reg1` instead of `PC_D`
- `ImmExt`  in  D_WIDTH  extended immediate of instruction in D
- `reg1`  in  D_WIDTH  rs1 value from datapath
- `imem_req`  out  1  fetch request
- `imem_addr`  out  D_WIDTH  fetch address, word-aligned
- `imem_ack`  in  1  `imem_rdata` valid this cycle; may coincide with `imem_req` rising (zero wait)
- `imem_rdata`  in  32  fetched instruction
- `instr_D`  out  32  instruction to decode
- `PC_D`  out  D_WIDTH  address of `instr_D`
- `valid_D`  out  1  `instr_D` is real
- `inc_PC`  out  D_WIDTH  `PC_D`+4, combinational
- `PCTarget`  out  D_WIDTH  redirect target, combinational
- `misalign`  out  1  see Configuration

## Operation
- `PCTarget` = (`JALR` ? `reg1` : `PC_D`) + `ImmExt`, modulo 2^D_WIDTH; bit 0 cleared when `JALR`.
- States: FETCH (`imem_req`=1, `imem_addr`=`PC_F`), HOLD (`imem_req`=0, fetched word parked in hold buffer).
- FETCH, `imem_ack`, !`stall`: IF/D <= {`imem_rdata`, `PC_F`, valid=1}; `PC_F` <= `PC_F`+4; stay FETCH.
- FETCH, `imem_ack`, `stall`: word into hold buffer with its PC; IF/D unchanged; `PC_F` <= `PC_F`+4; go HOLD.
- HOLD, !`stall`: IF/D <= hold buffer, valid=1; go FETCH.
- FETCH, no ack: request held, `imem_addr` stable until ack.
- `stall` with no ack: IF/D unchanged.
- Redirect (`PCSrc`=1) has priority over stall and ack: `PC_F` <= `PCTarget`; `valid_D` <= 0, `instr_D` <= `NOP`; hold buffer discarded; state FETCH.
- Redirect while a request is outstanding (req=1, ack=0): `kill` flag set; `imem_req` and old `imem_addr` stay asserted until ack; that ack's data dropped, kill cleared, then request `PCTarget` next cycle. Same-cycle redirect+ack: data dropped, no kill needed.
- `PC_F` increment wraps modulo 2^D_WIDTH.

## Timing
- Reset (async): `PC_F`=`RESET_PC`, state FETCH, `kill`=0, `valid_D`=0, `instr_D`=`NOP`, `PC_D`=0, `misalign`=0; `imem_req`=0 while `rst`=1, 1 from first cycle after release.
- Zero-wait memory, no stall: one instruction per cycle; first `valid_D`=1 one cycle after reset release.
- Fetch-to-D latency: registered on ack edge; `instr_D` visible the cycle after ack.
- Redirect penalty: 1 bubble (zero-wait); plus remaining latency of killed request if outstanding.
- `rst` mid-request: request abandoned; memory must tolerate `imem_req` dropping without ack.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `PCTarget[1:0]`≠0 sets sticky `misalign`=1, `PC_F` not updated, `imem_req`=0, `valid_D`=0 until `rst`.
- Undefined: `PCTarget[1:0]` forced to 0 on redirect; `misalign` tied 0.

## Test plan
- Reset release, zero-wait memory returning addr as data -> `imem_addr` 0,4,8,…; `PC_D`=0 with `valid_D`=1 one cycle after release, then +4 per cycle.
- `stall` 3 cycles on ack of 0x8 -> IF/D holds 0x4; state HOLD, `imem_req`=0; after stall drop `PC_D`=0x8, next fetch 0xC, no instruction lost or duplicated.
- `PCSrc`=1, `PC_D`=0x10, `ImmExt`=0xFFFFFFF0 -> `PCTarget`=0x0, next `imem_addr`=0x0, one bubble (`valid_D`=0, `instr_D`=0x00000013).
- `JALR`=1, `reg1`=0x101, `ImmExt`=4 -> `PCTarget`=0x104; 3-cycle-latency memory with redirect during wait -> stale word dropped, then request 0x104.
- `PC_F`=0xFFFFFFFC ack -> next `imem_addr`=0x0.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x102 -> `misalign`=1 sticky, `imem_req`=0; without macro: fetch issued at 0x100.
